// File: rtl/esm_report_arbiter_if.sv
// ---------------------------------------------------------------------------
// esm_report_arbiter_if
//   Stream bundle between the report sources / DMA sink and the report
//   arbiter.
//
//   Input_valid  [N]      source -> arbiter  per-source beat valid
//   Input_data   [N][DW]  source -> arbiter  per-source beat data
//   Input_last   [N]      source -> arbiter  per-source end of packet
//   Input_ready  [N]      arbiter -> source  per-source accept (one-hot or zero)
//   Output_ready          sink -> arbiter    downstream accept
//   Output_valid          arbiter -> sink    registered beat valid
//   Output_data  [DW]     arbiter -> sink    registered beat data
//   Output_last           arbiter -> sink    registered end of packet
//
//   master : environment side (sources and downstream sink)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface esm_report_arbiter_if #(
    parameter int unsigned NUM_INPUTS     = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [NUM_INPUTS-1:0]                     Input_valid;
    logic [NUM_INPUTS-1:0][AXI_DATA_WIDTH-1:0] Input_data;
    logic [NUM_INPUTS-1:0]                     Input_last;
    logic [NUM_INPUTS-1:0]                     Input_ready;

    logic                                      Output_ready;
    logic                                      Output_valid;
    logic [AXI_DATA_WIDTH-1:0]                 Output_data;
    logic                                      Output_last;

    modport master (
        output Input_valid,
        output Input_data,
        output Input_last,
        input  Input_ready,
        output Output_ready,
        input  Output_valid,
        input  Output_data,
        input  Output_last
    );

    modport slave (
        input  Input_valid,
        input  Input_data,
        input  Input_last,
        output Input_ready,
        input  Output_ready,
        output Output_valid,
        output Output_data,
        output Output_last
    );
endinterface

// File: rtl/esm_report_arbiter.sv
// ---------------------------------------------------------------------------
// esm_report_arbiter
//   Packet-level round-robin merge of report streams onto the single ESM
//   report stream. A granted source owns the output until its last beat,
//   so packets never interleave. The output stage is a single register that
//   still sustains one beat per cycle. Packets longer than
//   MAX_WORDS_PER_PACKET are cut: the MAX-th beat goes out with last forced,
//   Error_overlength pulses, and the rest of the packet is drained and
//   dropped.
//
//   Clk               in   rising-edge clock
//   Rst_n             in   synchronous reset, active low
//   Enable            in   permits new grants (sampled only while idle)
//   bus               slave modport of esm_report_arbiter_if (streams)
//   Error_overlength  out  one-cycle pulse, aligned with the truncated beat
//                          appearing on Output_valid
// ---------------------------------------------------------------------------
module esm_report_arbiter #(
    parameter int unsigned NUM_INPUTS           = 4,
    parameter int unsigned AXI_DATA_WIDTH       = 32,
    parameter int unsigned MAX_WORDS_PER_PACKET = 64
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Enable,
    esm_report_arbiter_if.slave  bus,
    output logic                 Error_overlength
);

    localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS_PER_PACKET + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W:0]   NUM_WIDE  = (IDX_W + 1)'(NUM_INPUTS);
    localparam logic [CNT_W-1:0] TRUNC_CNT = CNT_W'(MAX_WORDS_PER_PACKET - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [AXI_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;
    logic                      err_q, err_d;

    logic                      slot_free;
    logic                      cur_valid;
    logic                      cur_last;
    logic [AXI_DATA_WIDTH-1:0] cur_data;
    logic                      accept;
    logic                      trunc;
    logic [IDX_W-1:0]          next_ptr;

    logic                      pick_found;
    logic [IDX_W-1:0]          pick_idx;
    logic [IDX_W:0]            cand_sum;
    logic [IDX_W-1:0]          cand_idx;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    assign slot_free = !out_valid_q || bus.Output_ready;
    assign cur_valid = bus.Input_valid[grant_q];
    assign cur_last  = bus.Input_last[grant_q];
    assign cur_data  = bus.Input_data[grant_q];
    assign accept    = (state_q == S_ACTIVE) && cur_valid && slot_free;

    // The beat being accepted is number word_cnt_q + 1.
    assign trunc     = (word_cnt_q == TRUNC_CNT) && !cur_last;

    assign next_ptr  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

    // -----------------------------------------------------------------------
    // Rotational pick: first valid source at or after rr_ptr_q. The wrap is
    // a compare-and-subtract so non-power-of-two NUM_INPUTS need no divider.
    // -----------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_WIDE) begin
                cand_sum = cand_sum - NUM_WIDE;
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!pick_found && bus.Input_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-source ready: only the granted source, and only outside S_IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.Input_ready = '0;
        if (state_q == S_ACTIVE) begin
            bus.Input_ready[grant_q] = slot_free;
        end else if (state_q == S_FLUSH) begin
            bus.Input_ready[grant_q] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output-stage logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q && !bus.Output_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Enable && pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_data;
                    out_last_d  = cur_last || trunc;
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    if (cur_last) begin
                        state_d    = S_IDLE;
                        word_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                    end else if (trunc) begin
                        state_d    = S_FLUSH;
                        word_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                        err_d      = 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                if (cur_valid && cur_last) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            word_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign bus.Output_valid = out_valid_q;
    assign bus.Output_data  = out_data_q;
    assign bus.Output_last  = out_last_q;
    assign Error_overlength = err_q;

endmodule

// File: tb/tb_esm_report_arbiter.sv
module tb_esm_report_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXW = 64;

    logic Clk    = 1'b0;
    logic Rst_n  = 1'b0;
    logic Enable = 1'b1;
    logic Error_overlength;

    esm_report_arbiter_if #(.NUM_INPUTS(N), .AXI_DATA_WIDTH(DW)) bus ();

    esm_report_arbiter #(
        .NUM_INPUTS          (N),
        .AXI_DATA_WIDTH      (DW),
        .MAX_WORDS_PER_PACKET(MAXW)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Enable          (Enable),
        .bus             (bus),
        .Error_overlength(Error_overlength)
    );

    always #5 Clk = ~Clk;

    // Source beat queues ({last, data}) and expected output stream.
    logic [DW:0] srcq [N][$];
    logic [DW:0] expq [$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Packet-level reference model.
    int m_rr     = 0;
    int m_cur    = -1;
    int m_beats  = 0;
    bit err_pending = 1'b0;

    int cyc          = 0;
    int last_end_cyc = -1;
    bit chk_gap      = 1'b0;
    bit rnd_ready    = 1'b0;
    bit in_reset     = 1'b1;
    int err_seen     = 0;
    int out_cnt      = 0;
    int first_grant  = -1;
    int pkt_id       = 0;

    logic [N-1:0]  s_ready  = '0;
    logic          s_ovalid = 1'b0;
    logic [DW-1:0] s_odata  = '0;
    logic          s_olast  = 1'b0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(int s, int len, bit rnd);
        logic [DW:0] e;
        for (int b = 1; b <= len; b++) begin
            e[DW]     = (b == len);
            e[DW-1:0] = rnd ? DW'($urandom) : {4'(s), 12'(pkt_id), 16'(b)};
            srcq[s].push_back(e);
        end
        pkt_id++;
    endtask

    task automatic drive();
        logic [DW:0] e;
        for (int s = 0; s < N; s++) begin
            if (srcq[s].size() > 0) begin
                e = srcq[s][0];
                bus.Input_valid[s] = 1'b1;
                bus.Input_data[s]  = e[DW-1:0];
                bus.Input_last[s]  = e[DW];
            end else begin
                bus.Input_valid[s] = 1'b0;
                bus.Input_data[s]  = '0;
                bus.Input_last[s]  = 1'b0;
            end
        end
        bus.Output_ready = rnd_ready ? ($urandom_range(0, 99) < 80) : 1'b1;
    endtask

    // Observes the handshakes that will complete on the coming rising edge.
    task automatic sample();
        logic [N-1:0] acc;
        logic [DW:0]  e;
        int           s;
        int           winner;
        int           j;
        s_ready  = bus.Input_ready;
        s_ovalid = bus.Output_valid;
        s_odata  = bus.Output_data;
        s_olast  = bus.Output_last;
        if (in_reset) begin
            err_pending = 1'b0;
            return;
        end
        if (Error_overlength === 1'b1) err_seen++;
        check("err_pulse", Error_overlength, err_pending);
        err_pending = 1'b0;
        check("ready_onehot0", $onehot0(bus.Input_ready), 1);

        if (bus.Output_valid && bus.Output_ready) begin
            out_cnt++;
            check("out_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("out_data", bus.Output_data, e[DW-1:0]);
                check("out_last", bus.Output_last, e[DW]);
            end
        end

        acc = bus.Input_valid & bus.Input_ready;
        if (acc != '0) begin
            s = 0;
            for (int i = 0; i < N; i++) if (acc[i]) s = i;
            if (m_cur < 0) begin
                winner = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (winner < 0 && srcq[j].size() > 0) winner = j;
                end
                check("grant", s, winner);
                if (chk_gap && last_end_cyc >= 0) check("pkt_gap", cyc - last_end_cyc, 2);
                if (first_grant < 0) first_grant = s;
                m_cur   = s;
                m_beats = 0;
            end else begin
                check("no_interleave", s, m_cur);
            end
            e = srcq[s].pop_front();
            m_beats++;
            if (m_beats < MAXW || (m_beats == MAXW && e[DW])) begin
                expq.push_back(e);
            end else if (m_beats == MAXW) begin
                expq.push_back({1'b1, e[DW-1:0]});
                err_pending = 1'b1;
            end
            if (e[DW]) begin
                m_rr         = (m_cur + 1) % N;
                m_cur        = -1;
                last_end_cyc = cyc;
            end
        end
    endtask

    task automatic cycle();
        @(negedge Clk);
        drive();
        #1;
        sample();
        cyc++;
    endtask

    function automatic bit busy();
        bit b;
        b = (expq.size() != 0) || s_ovalid || (m_cur >= 0);
        for (int s = 0; s < N; s++) if (srcq[s].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_idle(int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (busy() && n < budget);
        check("drain_in_budget", busy(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tot;
        int sel;
        int len;

        // Reset and reset values.
        in_reset = 1'b1;
        Rst_n    = 1'b0;
        repeat (3) cycle();
        Rst_n    = 1'b1;
        in_reset = 1'b0;
        cycle();
        check("rst_out_valid", s_ovalid, 0);
        check("rst_out_last", s_olast, 0);
        check("rst_out_data", s_odata, 0);
        check("rst_in_ready", s_ready, 0);

        // Max-length legal packet, latency.
        out_cnt  = 0;
        err_seen = 0;
        add_pkt(0, MAXW, 1'b0);
        cycle();
        check("lat_n_ready", s_ready, 0);
        check("lat_n_ovalid", s_ovalid, 0);
        cycle();
        check("lat_n1_ready", s_ready, 4'b0001);
        check("lat_n1_ovalid", s_ovalid, 0);
        cycle();
        check("lat_n2_ovalid", s_ovalid, 1);
        run_until_idle(300);
        check("maxpkt_no_err", err_seen, 0);
        check("maxpkt_beats", out_cnt, MAXW);

        // All sources continuously valid, 3-beat packets.
        out_cnt = 0;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) add_pkt(s, 3, 1'b0);
        chk_gap      = 1'b1;
        last_end_cyc = -1;
        run_until_idle(300);
        chk_gap = 1'b0;
        check("rr_beats", out_cnt, 36);

        // Random packets from sources 0,1,3 with 80% Output_ready.
        out_cnt = 0;
        tot     = 0;
        for (int p = 0; p < 20; p++) begin
            sel = $urandom_range(0, 2);
            len = $urandom_range(1, 10);
            add_pkt((sel == 2) ? 3 : sel, len, 1'b1);
            tot += len;
        end
        rnd_ready = 1'b1;
        run_until_idle(2000);
        rnd_ready = 1'b0;
        check("rand_beats", out_cnt, tot);

        // Overlength packet on source 2, then 3 then 1 follow.
        out_cnt  = 0;
        err_seen = 0;
        add_pkt(2, 70, 1'b0);
        repeat (3) cycle();
        add_pkt(1, 2, 1'b0);
        add_pkt(3, 2, 1'b0);
        run_until_idle(400);
        check("ovl_err_count", err_seen, 1);
        check("ovl_out_beats", out_cnt, MAXW + 4);

        // Enable low blocks grants.
        Enable = 1'b0;
        add_pkt(1, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("en_low_ready", s_ready, 0);
        end
        check("en_low_pending", srcq[1].size(), 3);
        Enable = 1'b1;
        run_until_idle(100);

        // Enable dropped mid-packet: packet completes, no further grant.
        add_pkt(2, 10, 1'b0);
        add_pkt(3, 3, 1'b0);
        repeat (3) cycle();
        Enable = 1'b0;
        repeat (20) cycle();
        check("en_drop_done", srcq[2].size(), 0);
        check("en_drop_held", srcq[3].size(), 3);
        check("en_drop_out", expq.size(), 0);
        check("en_drop_ready", s_ready, 0);
        Enable = 1'b1;
        run_until_idle(100);

        // Reset mid-packet with rr_ptr away from 0.
        add_pkt(1, 1, 1'b0);
        run_until_idle(50);
        add_pkt(2, 20, 1'b0);
        repeat (6) cycle();
        check("pre_rst_ovalid", s_ovalid, 1);
        for (int s = 0; s < N; s++) srcq[s].delete();
        in_reset = 1'b1;
        Rst_n    = 1'b0;
        cycle();
        Rst_n    = 1'b1;
        in_reset = 1'b0;
        expq.delete();
        m_rr        = 0;
        m_cur       = -1;
        first_grant = -1;
        add_pkt(3, 1, 1'b0);
        add_pkt(1, 1, 1'b0);
        add_pkt(2, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        cycle();
        check("post_rst_ovalid", s_ovalid, 0);
        check("post_rst_idle", s_ready, 0);
        cycle();
        check("post_rst_grant0", s_ready, 4'b0001);
        run_until_idle(100);
        check("post_rst_first", first_grant, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
